// File: rtl/clearable_mem.sv
// clearable_mem
//   One bank of a ping-pong frame buffer: a simple dual-port memory of
//   2^A words x S bits. It has one write port and one registered read port
//   on a single clock. A reset pulse clears the whole bank at once. The
//   clear acts on a per-word valid bitmap, so the data array needs no
//   reset and can map onto a plain inferred RAM.
//
// Ports
//   clock         : single clock for write, read and valid bitmap
//   reset         : async active-high clear of contents and data_read
//   address_write : write address
//   data_write    : write data
//   wren          : write enable, sampled on rising clock
//   address_read  : read address, sampled on rising clock
//   data_read     : registered read data, 1-clock latency
module clearable_mem #(
    parameter int A = 9,
    parameter int S = 24
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [A-1:0] address_write,
    input  logic [S-1:0] data_write,
    input  logic         wren,
    input  logic [A-1:0] address_read,
    output logic [S-1:0] data_read
);

    localparam int DEPTH = 2 ** A;

    // Data storage: no reset, so it stays RAM-inferable.
    logic [S-1:0]     r_mem [DEPTH];
    // Power-up value makes the bank read as zeros before any reset.
    logic [DEPTH-1:0] r_valid = '0;
    logic [S-1:0]     r_data_read;
    logic             w_wr;

    // Writes while reset is high are dropped, for both the array and the
    // bitmap, so a write overlapping a clear never resurrects data.
    assign w_wr = wren & ~reset;

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[address_write] <= data_write;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (wren) begin
            r_valid[address_write] <= 1'b1;
        end
    end

    // The read samples the pre-edge array and bitmap, which gives
    // read-before-write when both ports hit the same address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_read <= '0;
        end else begin
            r_data_read <= r_valid[address_read] ? r_mem[address_read] : '0;
        end
    end

    assign data_read = r_data_read;

endmodule

// File: tb/tb_clearable_mem.sv
module tb_clearable_mem;
    localparam int A = 9;
    localparam int S = 24;
    localparam int DEPTH = 2 ** A;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [A-1:0] address_write = '0;
    logic [S-1:0] data_write = '0;
    logic         wren = 1'b0;
    logic [A-1:0] address_read = '0;
    logic [S-1:0] data_read;

    int nvec = 0;
    int nerr = 0;

    clearable_mem #(.A(A), .S(S)) dut (
        .clock         (clock),
        .reset         (reset),
        .address_write (address_write),
        .data_write    (data_write),
        .wren          (wren),
        .address_read  (address_read),
        .data_read     (data_read)
    );

    always #5 clock = ~clock;

    // Behavioural model: logical contents as an array plus "written" flags.
    logic [S-1:0] m_mem [DEPTH];
    bit           m_wr  [DEPTH];
    logic [S-1:0] m_exp = '0;
    bit           armed = 1'b0;

    task automatic check(input string nm, input logic [S-1:0] got, input logic [S-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %06h expected %06h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
                m_exp = '0;
                armed = 1'b1;
            end else begin
                m_exp = m_wr[address_read] ? m_mem[address_read] : '0;
                if (wren) begin
                    m_mem[address_write] = data_write;
                    m_wr[address_write]  = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (armed) check("model", data_read, m_exp);
    end

    // Drive one cycle of inputs, return just after the capturing edge.
    task automatic step(input logic we, input int aw, input logic [S-1:0] dw, input int ar);
        @(negedge clock);
        wren          = we;
        address_write = aw[A-1:0];
        data_write    = dw;
        address_read  = ar[A-1:0];
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 check("reset_async", data_read, 24'h0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        // Fresh bank reads zero.
        step(0, 0, 0, 0);   check("rd0_after_rst", data_read, 24'h0);
        step(0, 0, 0, 1);   check("rd1_after_rst", data_read, 24'h0);
        step(0, 0, 0, 511); check("rd511_after_rst", data_read, 24'h0);

        // Basic writes, with boundary address.
        step(1, 3, 24'hFF0000, 0);
        step(1, 511, 24'h00FF00, 0);
        step(0, 0, 0, 3);   check("rd3", data_read, 24'hFF0000);
        step(0, 0, 0, 511); check("rd511", data_read, 24'h00FF00);
        step(0, 0, 0, 4);   check("rd4_unwritten", data_read, 24'h0);

        // Read-before-write on the same address.
        step(1, 7, 24'hABCDEF, 0);
        step(1, 7, 24'h123456, 7); check("rbw_old", data_read, 24'hABCDEF);
        step(0, 0, 0, 7);          check("rbw_new", data_read, 24'h123456);

        // Same-cycle write and read on different addresses.
        step(1, 8, 24'h0F0F0F, 3); check("diff_addr", data_read, 24'hFF0000);
        step(0, 0, 0, 8);          check("diff_addr_wr", data_read, 24'h0F0F0F);

        // Fill, then asynchronous clear mid-cycle.
        for (int i = 0; i < DEPTH; i++) step(1, i, S'(i), 0);
        step(0, 0, 0, 5); check("fill_rd5", data_read, 24'h000005);
        #1 reset = 1'b1;
        #1 check("async_clear", data_read, 24'h0);
        #10 reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, i);
            if (i % 64 == 0 || i == DEPTH - 1) check("cleared", data_read, 24'h0);
        end

        // Writes during a held reset are discarded.
        @(negedge clock);
        reset = 1'b1; wren = 1'b1; address_write = 10; data_write = 24'h0000FF;
        @(negedge clock); @(negedge clock);
        reset = 1'b0; wren = 1'b0;
        step(0, 0, 0, 10); check("wr_in_reset", data_read, 24'h0);

        // Back-to-back write then read.
        step(1, 20, 24'h55AA33, 0);
        step(0, 0, 0, 20); check("b2b", data_read, 24'h55AA33);
        step(0, 0, 0, 20); check("hold", data_read, 24'h55AA33);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
